bcd_time_core: RTL and testbench

- Timekeeping stage that sits directly upstream of the alarm block.
- Divides CLOCK_50 into a 1 Hz tick and keeps packed-BCD hours, minutes and seconds.
- Drives the `second`/`minute`/`hour` buses consumed by the alarm comparator and the LCD path.
- Provides a digit-by-digit time-set mode driven by debounced pushbutton levels.

---
 rtl/clock_pkg.sv | 33 +++
 rtl/edge_sync.sv | 31 +++
 rtl/bcd_time_core.sv | 187 ++++++++++++++++++
 tb/tb_bcd_time_core.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared BCD limits, digit-select encoding and time record for the clock and alarm blocks.
package clock_pkg;

    localparam logic [2:0] SEC_T_MAX    = 3'd5;
    localparam logic [2:0] MIN_T_MAX    = 3'd5;
    localparam logic [1:0] HR_T_MAX     = 2'd2;
    localparam logic [3:0] HR_U_MAX_AT2 = 4'd3;
    localparam logic [3:0] UNIT_MAX     = 4'd9;

    localparam logic [1:0] SEL_MIN_U = 2'd0;
    localparam logic [1:0] SEL_MIN_T = 2'd1;
    localparam logic [1:0] SEL_HR_U  = 2'd2;
    localparam logic [1:0] SEL_HR_T  = 2'd3;

    typedef struct packed {
        logic [1:0] hr_t;
        logic [3:0] hr_u;
        logic [2:0] min_t;
        logic [3:0] min_u;
        logic [2:0] sec_t;
        logic [3:0] sec_u;
    } bcd_time_t;

    // Hour units stop at 3 in the twenties (20..23), otherwise at 9.
    function automatic logic [3:0] hr_u_max(input logic [1:0] hr_t);
        return (hr_t == HR_T_MAX) ? HR_U_MAX_AT2 : UNIT_MAX;
    endfunction

    function automatic logic [3:0] sel_onehot(input logic [1:0] sel);
        return 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchroniser for level inputs, with rising/falling edge pulses on the synchronised level.
module edge_sync #(
    parameter int STAGES = 2,   // must be at least 2
    parameter int WIDTH  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]             prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = level_o & ~prev_q;
    assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/bcd_time_core.sv
// BCD hh:mm:ss timekeeper with a 1 Hz prescaler and a pushbutton digit-by-digit time-set mode.
module bcd_time_core
    import clock_pkg::*;
#(
    parameter int TICK_DIV    = 50_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLOCK_50,
    input  logic       rst_n,
    input  logic       adjust_time,
    input  logic       select_add,
    input  logic       add,
    input  logic       clr,
    output logic [6:0] second,
    output logic [6:0] minute,
    output logic [5:0] hour,
    output logic [3:0] select_one,
    output logic       tick_1hz
);

    localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic {
        MODE_RUN,
        MODE_ADJ
    } mode_e;

    mode_e         mode_q, mode_d;
    bcd_time_t     time_q, time_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    select_q, select_d;

    logic       adj_level, adj_rise, adj_fall;
    logic [2:0] btn_level, btn_rise, btn_fall;
    logic       sel_p, add_p, clr_p, tick;
    logic       unused_sync;

    edge_sync #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_adj_sync (
        .clk     (CLOCK_50),
        .rst_n   (rst_n),
        .d_i     (adjust_time),
        .level_o (adj_level),
        .rise_o  (adj_rise),
        .fall_o  (adj_fall)
    );

    edge_sync #(.STAGES(SYNC_STAGES), .WIDTH(3)) u_btn_sync (
        .clk     (CLOCK_50),
        .rst_n   (rst_n),
        .d_i     ({clr, add, select_add}),
        .level_o (btn_level),
        .rise_o  (btn_rise),
        .fall_o  (btn_fall)
    );

    assign sel_p       = btn_rise[0];
    assign add_p       = btn_rise[1];
    assign clr_p       = btn_rise[2];
    assign unused_sync = ^{adj_level, btn_level, btn_fall};

    function automatic bcd_time_t advance(input bcd_time_t t);
        bcd_time_t n;
        n = t;
        if (t.sec_u != UNIT_MAX) n.sec_u = t.sec_u + 4'd1;
        else begin
            n.sec_u = '0;
            if (t.sec_t != SEC_T_MAX) n.sec_t = t.sec_t + 3'd1;
            else begin
                n.sec_t = '0;
                if (t.min_u != UNIT_MAX) n.min_u = t.min_u + 4'd1;
                else begin
                    n.min_u = '0;
                    if (t.min_t != MIN_T_MAX) n.min_t = t.min_t + 3'd1;
                    else begin
                        n.min_t = '0;
                        if (t.hr_u != hr_u_max(t.hr_t)) n.hr_u = t.hr_u + 4'd1;
                        else begin
                            n.hr_u = '0;
                            n.hr_t = (t.hr_t == HR_T_MAX) ? 2'd0 : t.hr_t + 2'd1;
                        end
                    end
                end
            end
        end
        return n;
    endfunction

    // Digit edits never carry into a neighbouring digit.
    function automatic bcd_time_t add_digit(input bcd_time_t t, input logic [1:0] sel);
        bcd_time_t n;
        n = t;
        case (sel)
            SEL_MIN_U: n.min_u = (t.min_u == UNIT_MAX)  ? 4'd0 : t.min_u + 4'd1;
            SEL_MIN_T: n.min_t = (t.min_t == MIN_T_MAX) ? 3'd0 : t.min_t + 3'd1;
            SEL_HR_U:  n.hr_u  = (t.hr_u == hr_u_max(t.hr_t)) ? 4'd0 : t.hr_u + 4'd1;
            SEL_HR_T: begin
                n.hr_t = (t.hr_t == HR_T_MAX) ? 2'd0 : t.hr_t + 2'd1;
                if (n.hr_t == HR_T_MAX && t.hr_u > HR_U_MAX_AT2) n.hr_u = '0;
            end
        endcase
        return n;
    endfunction

    function automatic bcd_time_t clr_digit(input bcd_time_t t, input logic [1:0] sel);
        bcd_time_t n;
        n = t;
        case (sel)
            SEL_MIN_U: n.min_u = '0;
            SEL_MIN_T: n.min_t = '0;
            SEL_HR_U:  n.hr_u  = '0;
            SEL_HR_T:  n.hr_t  = '0;
        endcase
        return n;
    endfunction

    assign tick = (mode_q == MODE_RUN) && (presc_q == PRESC_MAX);

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        mode_d   = mode_q;
        time_d   = time_q;
        presc_d  = presc_q;
        select_d = select_q;

        case (mode_q)
            MODE_RUN: begin
                if (tick) time_d = advance(time_q);
                presc_d = (tick || adj_rise) ? '0 : presc_q + 1'b1;
                if (adj_rise) begin
                    mode_d   = MODE_ADJ;
                    select_d = SEL_MIN_U;
                end
            end
            MODE_ADJ: begin
                presc_d = '0;
                if (adj_fall) begin
                    mode_d       = MODE_RUN;
                    select_d     = SEL_MIN_U;
                    time_d.sec_t = '0;
                    time_d.sec_u = '0;
                end else begin
                    if (sel_p) select_d = select_q + 2'd1;
                    // Digit ops act on the select value held before any simultaneous select_add.
                    if (clr_p)      time_d = clr_digit(time_q, select_q);
                    else if (add_p) time_d = add_digit(time_q, select_q);
                end
            end
        endcase

        // A corrupted (non-BCD or out-of-range) group is scrubbed back to zero.
        if (time_q.sec_t > SEC_T_MAX || time_q.sec_u > UNIT_MAX) begin
            time_d.sec_t = '0;
            time_d.sec_u = '0;
        end
        if (time_q.min_t > MIN_T_MAX || time_q.min_u > UNIT_MAX) begin
            time_d.min_t = '0;
            time_d.min_u = '0;
        end
        if (time_q.hr_t > HR_T_MAX || time_q.hr_u > hr_u_max(time_q.hr_t)) begin
            time_d.hr_t = '0;
            time_d.hr_u = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= MODE_RUN;
            time_q   <= '0;
            presc_q  <= '0;
            select_q <= SEL_MIN_U;
        end else begin
            mode_q   <= mode_d;
            time_q   <= time_d;
            presc_q  <= presc_d;
            select_q <= select_d;
        end
    end

    assign second     = {time_q.sec_t, time_q.sec_u};
    assign minute     = {time_q.min_t, time_q.min_u};
    assign hour       = {time_q.hr_t, time_q.hr_u};
    assign select_one = (mode_q == MODE_ADJ) ? sel_onehot(select_q) : 4'b0000;
    assign tick_1hz   = tick;

endmodule

// File: tb/tb_bcd_time_core.sv
// Directed, table-driven bench for bcd_time_core with a 4-cycle second.
module tb_bcd_time_core;

    localparam int TICK_DIV = 4;

    localparam logic [2:0] OP_SEL  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_CLR  = 3'b100;
    localparam logic [2:0] OP_BOTH = 3'b110;

    typedef struct {
        int         sel;
        logic [2:0] op;
        int         count;
        logic [6:0] exp_min;
        logic [5:0] exp_hr;
        logic [3:0] exp_sel1;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       adjust_time = 1'b0;
    logic       select_add = 1'b0;
    logic       add = 1'b0;
    logic       clr = 1'b0;
    logic [6:0] second, minute;
    logic [5:0] hour;
    logic [3:0] select_one;
    logic       tick_1hz;

    int   checks = 0;
    int   errors = 0;
    int   cur_sel = 0;
    logic hour_bad = 1'b0;
    vec_t vecs [20];

    always #5 clk = ~clk;

    bcd_time_core #(.TICK_DIV(TICK_DIV), .SYNC_STAGES(2)) dut (
        .CLOCK_50    (clk),
        .rst_n       (rst_n),
        .adjust_time (adjust_time),
        .select_add  (select_add),
        .add         (add),
        .clr         (clr),
        .second      (second),
        .minute      (minute),
        .hour        (hour),
        .select_one  (select_one),
        .tick_1hz    (tick_1hz)
    );

    always @(negedge clk)
        if (rst_n && (hour[5:4] > 2'd2 || hour[3:0] > 4'd9 ||
                      (hour[5:4] == 2'd2 && hour[3:0] > 4'd3)))
            hour_bad <= 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic press(input logic [2:0] mask);
        {clr, add, select_add} = mask;
        repeat (4) @(negedge clk);
        {clr, add, select_add} = 3'b000;
        repeat (4) @(negedge clk);
    endtask

    task automatic goto_sel(input int s);
        while (cur_sel != s) begin
            press(OP_SEL);
            cur_sel = (cur_sel + 1) % 4;
        end
    endtask

    // Returns negedges spent waiting; leaves the bench one cycle after the tick.
    task automatic wait_tick(output int n);
        n = 0;
        while (!tick_1hz && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!tick_1hz) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout: got no tick after %0d cycles expected a tick", n);
        end
        @(negedge clk);
    endtask

    initial begin
        int n;
        int guard;

        vecs[0]  = '{0, OP_ADD,  3, 7'h04, 6'h00, 4'b0001};
        vecs[1]  = '{0, OP_ADD,  6, 7'h00, 6'h00, 4'b0001};
        vecs[2]  = '{1, OP_ADD,  4, 7'h40, 6'h00, 4'b0010};
        vecs[3]  = '{1, OP_ADD,  2, 7'h00, 6'h00, 4'b0010};
        vecs[4]  = '{1, OP_ADD,  4, 7'h40, 6'h00, 4'b0010};
        vecs[5]  = '{0, OP_ADD,  5, 7'h45, 6'h00, 4'b0001};
        vecs[6]  = '{1, OP_BOTH, 1, 7'h05, 6'h00, 4'b0010};
        vecs[7]  = '{2, OP_ADD,  7, 7'h05, 6'h07, 4'b0100};
        vecs[8]  = '{3, OP_ADD,  1, 7'h05, 6'h17, 4'b1000};
        vecs[9]  = '{3, OP_ADD,  1, 7'h05, 6'h20, 4'b1000};
        vecs[10] = '{3, OP_ADD,  1, 7'h05, 6'h00, 4'b1000};
        vecs[11] = '{3, OP_ADD,  1, 7'h05, 6'h10, 4'b1000};
        vecs[12] = '{2, OP_ADD, 12, 7'h05, 6'h12, 4'b0100};
        vecs[13] = '{3, OP_ADD,  1, 7'h05, 6'h22, 4'b1000};
        vecs[14] = '{2, OP_ADD,  2, 7'h05, 6'h20, 4'b0100};
        vecs[15] = '{2, OP_ADD,  3, 7'h05, 6'h23, 4'b0100};
        vecs[16] = '{3, OP_CLR,  1, 7'h05, 6'h03, 4'b1000};
        vecs[17] = '{3, OP_ADD,  2, 7'h05, 6'h23, 4'b1000};
        vecs[18] = '{1, OP_ADD,  5, 7'h55, 6'h23, 4'b0010};
        vecs[19] = '{0, OP_ADD,  4, 7'h59, 6'h23, 4'b0001};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_second", second, 7'h00);
        check("rst_minute", minute, 7'h00);
        check("rst_hour", hour, 6'h00);
        check("rst_select_one", select_one, 4'b0000);
        check("rst_tick", tick_1hz, 1'b0);
        rst_n = 1'b1;

        // Free run: 60 seconds roll the minute
        for (int i = 1; i <= 59; i++) begin
            wait_tick(n);
            if (i <= 4) check($sformatf("tick_period_%0d", i), n + 1, TICK_DIV);
            if (i == 1) check("tick_one_cycle", tick_1hz, 1'b0);
            if (i == 10) check("sec_at_10", second, 7'h10);
        end
        check("sec_at_59", second, 7'h59);
        check("min_at_59", minute, 7'h00);
        wait_tick(n);
        check("sec_wrap", second, 7'h00);
        check("min_carry", minute, 7'h01);
        wait_tick(n);
        check("sec_after_wrap", second, 7'h01);

        // Enter adjust: select_one appears on the third cycle
        adjust_time = 1'b1;
        repeat (2) @(negedge clk);
        check("adj_latency_early", select_one, 4'b0000);
        @(negedge clk);
        check("adj_latency", select_one, 4'b0001);
        cur_sel = 0;
        @(negedge clk);

        for (int v = 0; v < 20; v++) begin
            goto_sel(vecs[v].sel);
            repeat (vecs[v].count) press(vecs[v].op);
            check($sformatf("vec%0d_minute", v), minute, vecs[v].exp_min);
            check($sformatf("vec%0d_hour", v), hour, vecs[v].exp_hr);
            check($sformatf("vec%0d_select_one", v), select_one, vecs[v].exp_sel1);
        end
        check("sec_frozen", second, 7'h01);

        // select_add with add: digit op uses the old select
        goto_sel(0);
        press(OP_SEL | OP_ADD);
        cur_sel = 1;
        check("simul_minute", minute, 7'h50);
        check("simul_select_one", select_one, 4'b0010);
        goto_sel(0);
        repeat (9) press(OP_ADD);
        check("restore_minute", minute, 7'h59);

        // Leave adjust at 23:59
        adjust_time = 1'b0;
        repeat (2) @(negedge clk);
        check("leave_early_select_one", select_one, 4'b0001);
        @(negedge clk);
        check("leave_select_one", select_one, 4'b0000);
        check("leave_second", second, 7'h00);
        check("leave_hour", hour, 6'h23);
        wait_tick(n);
        check("resume_tick_delay", n, 3);

        // Button pulses in run mode are ignored
        press(OP_ADD);
        press(OP_CLR);
        press(OP_SEL);
        check("ignore_minute", minute, 7'h59);
        check("ignore_hour", hour, 6'h23);
        check("ignore_select_one", select_one, 4'b0000);

        guard = 0;
        while (second != 7'h58 && guard < 80) begin
            wait_tick(n);
            guard++;
        end
        check("reach_second_58", second, 7'h58);
        check("reach_minute", minute, 7'h59);
        check("reach_hour", hour, 6'h23);
        wait_tick(n);
        check("sec_235959", second, 7'h59);
        wait_tick(n);
        check("midnight_second", second, 7'h00);
        check("midnight_minute", minute, 7'h00);
        check("midnight_hour", hour, 6'h00);
        check("hour_never_illegal", hour_bad, 1'b0);

        // Reset in the middle of adjusting 14:37
        adjust_time = 1'b1;
        repeat (4) @(negedge clk);
        cur_sel = 0;
        repeat (7) press(OP_ADD);
        goto_sel(1);
        repeat (3) press(OP_ADD);
        goto_sel(2);
        repeat (4) press(OP_ADD);
        goto_sel(3);
        press(OP_ADD);
        check("preset_minute", minute, 7'h37);
        check("preset_hour", hour, 6'h14);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_second", second, 7'h00);
        check("midrst_minute", minute, 7'h00);
        check("midrst_hour", hour, 6'h00);
        check("midrst_select_one", select_one, 4'b0000);
        adjust_time = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_tick(n);
        check("post_rst_tick_delay", n, 3);
        check("post_rst_second", second, 7'h01);
        check("post_rst_minute", minute, 7'h00);
        check("post_rst_hour", hour, 6'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
